// File: rtl/rv_iommu_atr_ingress.sv
// Translation-request ingress FIFO feeding the IOMMU ATR port, with an in-flight issue throttle.
// Latency: an accepted request is presented on m_* the next cycle (no bypass); completions free a slot next cycle.
// Backpressure: s_trdy_o drops when the FIFO is full; m_irdy_o is held low while MAX_OUT requests are in flight.
module rv_iommu_atr_ingress #(
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [111:0]             s_req_i,
   input  logic                     s_irdy_i,
   output logic                     s_trdy_o,
   output logic [111:0]             m_req_o,
   output logic                     m_irdy_o,
   input  logic                     m_trdy_i,
   input  logic                     cpl_irdy_i,
   input  logic                     cpl_trdy_i,
   output logic [$clog2(DEPTH):0]   occupancy_o,
   output logic [7:0]               outstanding_o,
   output logic                     idle_o,
   output logic                     cpl_err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;

   // Storage is not reset: an entry is only ever read while occupancy covers it.
   logic [111:0]  mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;
   logic [7:0]    out_q, out_d;
   logic          err_q, err_d;

   logic          push;
   logic          pop;
   logic          cpl;
   logic          cpl_ok;

   // Both handshake-ready outputs come from registered state only, so there is
   // no combinational path from s_irdy_i to m_irdy_o and a full FIFO refuses
   // a push even in a cycle where it also pops.
   assign s_trdy_o      = (occ_q < OW'(DEPTH));
   assign m_irdy_o      = (occ_q != '0) && (out_q < 8'(MAX_OUT));
   assign m_req_o       = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign occupancy_o   = occ_q;
   assign outstanding_o = out_q;
   assign idle_o        = (occ_q == '0) && (out_q == '0);
   assign cpl_err_o     = err_q;

   assign push   = s_irdy_i && s_trdy_o;
   assign pop    = m_irdy_o && m_trdy_i;
   assign cpl    = cpl_irdy_i && cpl_trdy_i;
   // A completion with nothing in flight is flagged, never counted.
   assign cpl_ok = cpl && (out_q != '0);

   // Next-state for pointers, occupancy, in-flight count and sticky error.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      out_d    = out_q;
      err_d    = err_q;

      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      if (push && !pop)      occ_d = occ_q + OW'(1);
      else if (!push && pop) occ_d = occ_q - OW'(1);

      // MAX_OUT <= 255 keeps the 8-bit counter from wrapping.
      if (pop && !cpl_ok)      out_d = out_q + 8'd1;
      else if (!pop && cpl_ok) out_d = out_q - 8'd1;

      if (cpl && (out_q == '0)) err_d = 1'b1;
   end

   // Control state register; reset discards queued entries and in-flight tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         out_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         out_q    <= out_d;
         err_q    <= err_d;
      end
   end

   // Request storage write on an accepted push.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s_req_i;
   end

endmodule
